// File: rtl/pe_pkg.sv
// Shared constants, path-mode type and overflow helper for the systolic-array PE.
package pe_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned ACC_WIDTH_DEF  = 24;

  // Saturation bounds for the default accumulator width
  localparam logic [ACC_WIDTH_DEF-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH_DEF-1){1'b1}}};
  localparam logic [ACC_WIDTH_DEF-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH_DEF-1){1'b0}}};

  // Which datapath a cycle takes, decoded from the two incoming valids
  typedef enum logic [1:0] {
    PATH_IDLE   = 2'd0,
    PATH_BYPASS = 2'd1,
    PATH_MAC    = 2'd2
  } pe_path_e;

  // Signed add overflow from operand/result sign bits; width-independent so
  // the array-level adder tree can reuse it at any width.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/pe_weight_buf.sv
// Double-buffered weight store: shadow register on the column shift chain,
// active register feeding the multiplier, committed by a swap strobe.
module pe_weight_buf
  import pe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  w_vld_i,
  input  logic [DATA_WIDTH-1:0] w_i,
  input  logic                  swap_i,
  output logic                  w_vld_o,
  output logic [DATA_WIDTH-1:0] w_o,
  output logic [DATA_WIDTH-1:0] active_o
);

  logic [DATA_WIDTH-1:0] shadow_q, shadow_d;
  logic [DATA_WIDTH-1:0] active_q, active_d;
  logic [DATA_WIDTH-1:0] w_out_q,  w_out_d;
  logic                  w_vld_q,  w_vld_d;

  // Next-state: shift pushes old shadow downward; swap reads pre-shift shadow
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    w_out_d  = w_out_q;
    w_vld_d  = w_vld_i;
    if (w_vld_i) begin
      shadow_d = w_i;
      w_out_d  = shadow_q;
    end
    if (swap_i) begin
      active_d = shadow_q;
    end
  end

  // Weight registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shadow_q <= '0;
      active_q <= '0;
      w_out_q  <= '0;
      w_vld_q  <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      w_out_q  <= w_out_d;
      w_vld_q  <= w_vld_d;
    end
  end

  assign w_vld_o  = w_vld_q;
  assign w_o      = w_out_q;
  assign active_o = active_q;

endmodule

// File: rtl/pe_mac_cell.sv
// Systolic-array processing element: activations pass left to right, partial
// sums top to bottom, weights double-buffered down the column.
// Optional build macro PE_ACC_SAT_EN: clamp overflowing sums instead of wrapping.
module pe_mac_cell
  import pe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ACC_WIDTH  = ACC_WIDTH_DEF
) (
  input  logic                  PE_clk,
  input  logic                  PE_rst,
  input  logic                  PE_w_vld_in,
  input  logic [DATA_WIDTH-1:0] PE_w_in,
  output logic                  PE_w_vld_out,
  output logic [DATA_WIDTH-1:0] PE_w_out,
  input  logic                  PE_w_swap,
  input  logic                  PE_a_vld_in,
  input  logic [DATA_WIDTH-1:0] PE_a_in,
  output logic                  PE_a_vld_out,
  output logic [DATA_WIDTH-1:0] PE_a_out,
  input  logic                  PE_psum_vld_in,
  input  logic [ACC_WIDTH-1:0]  PE_psum_in,
  output logic                  PE_psum_vld_out,
  output logic [ACC_WIDTH-1:0]  PE_psum_out,
  output logic                  PE_ovf_flag,
  input  logic                  PE_flag_clr
);

  if (ACC_WIDTH < 2 * DATA_WIDTH) begin : g_bad_cfg
    $error("pe_mac_cell: ACC_WIDTH must be at least 2*DATA_WIDTH");
  end

  logic [DATA_WIDTH-1:0] active_w;

  pe_weight_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_wbuf (
    .clk_i    (PE_clk),
    .rst_i    (PE_rst),
    .w_vld_i  (PE_w_vld_in),
    .w_i      (PE_w_in),
    .swap_i   (PE_w_swap),
    .w_vld_o  (PE_w_vld_out),
    .w_o      (PE_w_out),
    .active_o (active_w)
  );

  logic                  a_vld_q,    a_vld_d;
  logic [DATA_WIDTH-1:0] a_q,        a_d;
  logic                  psum_vld_q, psum_vld_d;
  logic [ACC_WIDTH-1:0]  psum_q,     psum_d;
  logic                  ovf_q,      ovf_d;

  pe_path_e                    path;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]    prod_ext;
  logic signed [ACC_WIDTH-1:0]    addend;
  logic signed [ACC_WIDTH-1:0]    sum_raw;
  logic [ACC_WIDTH-1:0]           sum_sel;
  logic                           ovf_det;

  // Path decode from incoming valids
  always_comb begin
    path = PATH_IDLE;
    if (PE_a_vld_in)         path = PATH_MAC;
    else if (PE_psum_vld_in) path = PATH_BYPASS;
  end

  // Multiply with the currently registered (pre-swap) active weight
  assign prod     = $signed(PE_a_in) * $signed(active_w);
  assign prod_ext = ACC_WIDTH'(prod);
  assign addend   = PE_psum_vld_in ? $signed(PE_psum_in) : '0;
  assign sum_raw  = addend + prod_ext;
  assign ovf_det  = PE_psum_vld_in
                    && add_ovf(addend[ACC_WIDTH-1], prod_ext[ACC_WIDTH-1], sum_raw[ACC_WIDTH-1]);

`ifdef PE_ACC_SAT_EN
  localparam logic [ACC_WIDTH-1:0] SAT_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] SAT_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  // Clamp toward the sign of the operands when the add overflows
  always_comb begin
    sum_sel = sum_raw;
    if (ovf_det) sum_sel = addend[ACC_WIDTH-1] ? SAT_MIN : SAT_MAX;
  end
`else
  assign sum_sel = sum_raw;
`endif

  // Next-state for activation, partial-sum and sticky overflow registers
  always_comb begin
    a_d        = a_q;
    a_vld_d    = 1'b0;
    psum_d     = psum_q;
    psum_vld_d = 1'b0;
    ovf_d      = ovf_q & ~PE_flag_clr;
    case (path)
      PATH_MAC: begin
        a_d        = PE_a_in;
        a_vld_d    = 1'b1;
        psum_d     = sum_sel;
        psum_vld_d = 1'b1;
        if (ovf_det) ovf_d = 1'b1;
      end
      PATH_BYPASS: begin
        psum_d     = PE_psum_in;
        psum_vld_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath registers with synchronous reset
  always_ff @(posedge PE_clk) begin
    if (PE_rst) begin
      a_q        <= '0;
      a_vld_q    <= 1'b0;
      psum_q     <= '0;
      psum_vld_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      a_q        <= a_d;
      a_vld_q    <= a_vld_d;
      psum_q     <= psum_d;
      psum_vld_q <= psum_vld_d;
      ovf_q      <= ovf_d;
    end
  end

  assign PE_a_out        = a_q;
  assign PE_a_vld_out    = a_vld_q;
  assign PE_psum_out     = psum_q;
  assign PE_psum_vld_out = psum_vld_q;
  assign PE_ovf_flag     = ovf_q;

endmodule

// File: doc/pe_mac_cell.md
Name: pe_mac_cell

Overview:
- Parametrised general-purpose processing element for the NICE CNN systolic array. It replaces the fixed-position edge PEs.
- Weights are double-buffered: the next tile's weights shift down the column while the current tile computes.
- Activations flow left to right; partial sums flow top to bottom.
- One instance per array position. An edge PE is the same cell with unused inputs tied off.

Parameters:
- DATA_WIDTH, 8: signed activation and weight width.
- ACC_WIDTH, 24: signed partial-sum width; must be ≥ 2*DATA_WIDTH (elaboration-time check).

Ports:
- PE_clk  in  1  clock.
- PE_rst  in  1  synchronous reset, active-high.
- PE_w_vld_in  in  1  weight shift strobe from above.
- PE_w_in  in  DATA_WIDTH  weight from above.
- PE_w_vld_out  out  1  weight shift strobe to below.
- PE_w_out  out  DATA_WIDTH  displaced shadow weight to below.
- PE_w_swap  in  1  commit shadow weight to active weight.
- PE_a_vld_in  in  1  activation valid from left.
- PE_a_in  in  DATA_WIDTH  activation from left.
- PE_a_vld_out  out  1  activation valid to right.
- PE_a_out  out  DATA_WIDTH  registered activation to right.
- PE_psum_vld_in  in  1  partial sum valid from above; tie 0 on the top row.
- PE_psum_in  in  ACC_WIDTH  partial sum from above.
- PE_psum_vld_out  out  1  partial sum valid to below.
- PE_psum_out  out  ACC_WIDTH  partial sum to below.
- PE_ovf_flag  out  1  sticky overflow indicator.
- PE_flag_clr  in  1  clears PE_ovf_flag.

Behaviour:
- Reset: all outputs, the shadow weight, the active weight and the sticky flag go to 0 on the first PE_clk edge with PE_rst=1. Reset overrides every other input. Reset mid-operation drops any in-flight values; nothing is replayed.
- Weight chain:
  - On PE_w_vld_in: shadow <= PE_w_in; PE_w_out <= old shadow; PE_w_vld_out <= 1.
  - Otherwise PE_w_vld_out <= 0 and PE_w_out holds its value.
  - An N-row column is loaded with N strobes, bottom-row weight first.
- Swap: on PE_w_swap, active <= shadow. If PE_w_swap and PE_w_vld_in occur in the same cycle, active takes the pre-shift shadow value.
- Compute:
  - On PE_a_vld_in: PE_a_out <= PE_a_in; PE_a_vld_out <= 1.
  - prod = signed(PE_a_in) * signed(active), 2*DATA_WIDTH bits, sign-extended to ACC_WIDTH.
  - PE_psum_out <= PE_psum_in + prod if PE_psum_vld_in, else prod.
  - PE_psum_vld_out <= 1.
  - If PE_w_swap occurs in the same cycle, the multiply uses the pre-swap active weight.
- Bypass: PE_psum_vld_in=1 with PE_a_vld_in=0 forwards PE_psum_in unchanged, PE_psum_vld_out=1. Activation outputs hold and PE_a_vld_out=0.
- Idle: with neither valid asserted, both output valids go to 0 and the data outputs hold.
- Latency: exactly 1 cycle on every path. No backpressure; the upstream sequencer guarantees slots.
- Overflow:
  - Signed overflow of the ACC_WIDTH addition sets PE_ovf_flag. The flag stays set until PE_flag_clr or reset.
  - If PE_flag_clr coincides with a new overflow, the flag stays set (set wins).
- Widths: all arithmetic is two's complement. Without the optional feature, the sum wraps modulo 2^ACC_WIDTH.

Optional Feature:
- Macro: PE_ACC_SAT_EN.
- Defined: an overflowing sum clamps to +(2^(ACC_WIDTH-1)-1) or -2^(ACC_WIDTH-1), and PE_ovf_flag is set as above.
- Undefined: the sum wraps and PE_ovf_flag still reports overflow. The saturation logic is absent.

Decomposition:
- Shared package pe_pkg:
  - default DATA_WIDTH and ACC_WIDTH constants;
  - ACC_MAX and ACC_MIN constants;
  - a signed overflow-detect function, reused by the array-level adder tree.
- One sub-module, pe_weight_buf: holds the shadow and active registers, the chain outputs and the swap logic.
- The MAC datapath stays in pe_mac_cell.

Test Plan (DATA_WIDTH=8, ACC_WIDTH=20 unless noted):
- Shift 0x05 then 0x7F with PE_w_vld_in, then PE_w_swap. Required: PE_w_out=0x00 then 0x05; active=0x7F; PE_w_vld_out high 1 cycle after each strobe.
- active=-3, PE_a_in=4, psum_vld_in=1, PE_psum_in=100. Required: next cycle PE_psum_out=88, PE_a_out=4, both output valids=1.
- PE_w_swap together with PE_a_vld_in (old active=2, shadow=9, PE_a_in=10, psum_vld_in=0). Required: PE_psum_out=20; the next activation uses weight 9.
- Bypass: PE_psum_vld_in=1, PE_a_vld_in=0, PE_psum_in=0x12345. Required: PE_psum_out=0x12345, PE_a_vld_out=0.
- PE_psum_in=0x7FFF0, prod=+127*127=16129. Required: PE_ovf_flag=1. Sum wraps to 0x83EF1 without PE_ACC_SAT_EN; clamps to 0x7FFFF with it. PE_flag_clr then clears the flag.
- Assert PE_rst mid-stream with all valids high. Required: every output is 0 the next cycle and weights read back 0.
